demux_burst_scheduler: RTL and testbench

Stream scheduler that drives a 1:NUM_OUT demux from one input stream with valid/ready flow control. It sends bursts of BURST_LEN words to each enabled output in round-robin order. Each output has its own valid/ready pair, and all outputs share one registered data bus. The block sits between a single producer and NUM_OUT consumers and replaces a free-running select line with a sequenced one.

---
 rtl/demux_burst_scheduler.sv | 102 ++++++++++
 tb/tb_demux_burst_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/demux_burst_scheduler.sv
// rtl/demux_burst_scheduler.sv - round-robin burst scheduler feeding a 1:NUM_OUT demux
// Single-entry output register; the select advances only at burst boundaries.
module demux_burst_scheduler #(
  parameter int DATA_W    = 8,
  parameter int NUM_OUT   = 4,
  parameter int SEL_W     = 2,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [NUM_OUT-1:0] en,
  output logic [DATA_W-1:0]  y_data,
  output logic [NUM_OUT-1:0] y_valid,
  input  logic [NUM_OUT-1:0] y_ready,
  output logic [SEL_W-1:0]   s,
  output logic               burst_done
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic [SEL_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [SEL_W-1:0]  next_sel;
  logic [SEL_W-1:0]  idx;
  logic              found;
  logic              sel_ok, acc, retire, last;

  // First enabled output after sel, wrapping back to sel itself; sel unchanged if en==0.
  always_comb begin
    next_sel = sel_q;
    found    = 1'b0;
    idx      = sel_q;
    for (int k = 1; k <= NUM_OUT; k++) begin
      idx = sel_q + SEL_W'(k);
      if (!found && en[idx]) begin
        next_sel = idx;
        found    = 1'b1;
      end
    end
  end

  assign sel_ok     = en[sel_q] | (cnt_q != '0);
  assign retire     = full_q & y_ready[tag_q];
  assign i_ready    = rst_n & sel_ok & (!full_q | y_ready[tag_q]);
  assign acc        = i_valid & i_ready;
  assign last       = (cnt_q == CNT_LAST);
  assign burst_done = acc & last;

  assign y_data  = data_q;
  assign y_valid = full_q ? (NUM_OUT'(1) << tag_q) : '0;
  assign s       = sel_q;

  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (acc) begin
      full_d = 1'b1;
      tag_d  = sel_q;
      data_d = i_data;
      if (last) begin
        cnt_d = '0;
        sel_d = next_sel;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (retire) begin
      full_d = 1'b0;
    end
    // Reselect: boundary reached on a disabled output, so hop before accepting.
    if (!sel_ok) begin
      sel_d = next_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// tb/tb_demux_burst_scheduler.sv - directed vector bench for demux_burst_scheduler
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
module tb_demux_burst_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_ready;
  logic [3:0] en;
  logic [7:0] y_data;
  logic [3:0] y_valid;
  logic [3:0] y_ready;
  logic [1:0] s;
  logic       burst_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_burst_scheduler #(.DATA_W(8), .NUM_OUT(4), .SEL_W(2), .BURST_LEN(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .en(en), .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .s(s),
    .burst_done(burst_done)
  );

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic       iv;
    logic [7:0] d;
    logic [3:0] yr;
    logic       ir;
    logic [3:0] yv;
    logic [7:0] yd;
    logic [1:0] s;
    logic       bd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] e, logic iv, logic [7:0] d, logic [3:0] yr,
                              logic ir, logic [3:0] yv, logic [7:0] yd, logic [1:0] sx, logic bd);
    vec_t v;
    v.rst = r; v.en = e; v.iv = iv; v.d = d; v.yr = yr;
    v.ir = ir; v.yv = yv; v.yd = yd; v.s = sx; v.bd = bd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst_n = v.rst; en = v.en; i_valid = v.iv; i_data = v.d; y_ready = v.yr;
    @(negedge clk);
    chk("i_ready", idx, 32'(i_ready), 32'(v.ir));
    chk("y_valid", idx, 32'(y_valid), 32'(v.yv));
    if (v.yv != 4'h0) chk("y_data", idx, 32'(y_data), 32'(v.yd));
    chk("s", idx, 32'(s), 32'(v.s));
    chk("burst_done", idx, 32'(burst_done), 32'(v.bd));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    vecs.push_back(mk(0, 4'hF, 1, 8'h99, 4'hF, 0, 4'h0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 4'hF, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 0, 0));
    // Round robin over all four outputs
    vecs.push_back(mk(1, 4'hF, 1, 8'h10, 4'hF, 1, 4'h0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h11, 4'hF, 1, 4'h1, 8'h10, 0, 1));
    vecs.push_back(mk(1, 4'hF, 1, 8'h12, 4'hF, 1, 4'h1, 8'h11, 1, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h13, 4'hF, 1, 4'h2, 8'h12, 1, 1));
    vecs.push_back(mk(1, 4'hF, 1, 8'h14, 4'hF, 1, 4'h2, 8'h13, 2, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h15, 4'hF, 1, 4'h4, 8'h14, 2, 1));
    vecs.push_back(mk(1, 4'hF, 1, 8'h16, 4'hF, 1, 4'h4, 8'h15, 3, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h17, 4'hF, 1, 4'h8, 8'h16, 3, 1));
    vecs.push_back(mk(1, 4'hF, 0, 8'h00, 4'hF, 1, 4'h8, 8'h17, 0, 0));
    vecs.push_back(mk(1, 4'hF, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 0, 0));
    // Skip disabled outputs, en=1010
    vecs.push_back(mk(0, 4'hA, 0, 8'h00, 4'hF, 0, 4'h0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 4'hA, 1, 8'hA0, 4'hF, 0, 4'h0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 4'hA, 1, 8'hA0, 4'hF, 1, 4'h0, 8'h00, 1, 0));
    vecs.push_back(mk(1, 4'hA, 1, 8'hA1, 4'hF, 1, 4'h2, 8'hA0, 1, 1));
    vecs.push_back(mk(1, 4'hA, 1, 8'hA2, 4'hF, 1, 4'h2, 8'hA1, 3, 0));
    vecs.push_back(mk(1, 4'hA, 1, 8'hA3, 4'hF, 1, 4'h8, 8'hA2, 3, 1));
    vecs.push_back(mk(1, 4'hA, 0, 8'h00, 4'hF, 1, 4'h8, 8'hA3, 1, 0));
    vecs.push_back(mk(1, 4'hA, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 1, 0));
    // Backpressure on output 0
    vecs.push_back(mk(0, 4'hF, 0, 8'h00, 4'hF, 0, 4'h0, 8'h00, 1, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h55, 4'hF, 1, 4'h0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h56, 4'hE, 0, 4'h1, 8'h55, 0, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h56, 4'hE, 0, 4'h1, 8'h55, 0, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h56, 4'hE, 0, 4'h1, 8'h55, 0, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h56, 4'hF, 1, 4'h1, 8'h55, 0, 1));
    vecs.push_back(mk(1, 4'hF, 0, 8'h00, 4'hF, 1, 4'h1, 8'h56, 1, 0));
    vecs.push_back(mk(1, 4'hF, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 1, 0));
    // Mid-burst mask change
    vecs.push_back(mk(0, 4'hF, 0, 8'h00, 4'hF, 0, 4'h0, 8'h00, 1, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h20, 4'hF, 1, 4'h0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 4'h2, 1, 8'h21, 4'hF, 1, 4'h1, 8'h20, 0, 1));
    vecs.push_back(mk(1, 4'h2, 1, 8'h22, 4'hF, 1, 4'h1, 8'h21, 1, 0));
    vecs.push_back(mk(1, 4'h2, 0, 8'h00, 4'hF, 1, 4'h2, 8'h22, 1, 0));
    // en=0 at a boundary, then reset with a word held for output 2
    vecs.push_back(mk(1, 4'h2, 1, 8'h23, 4'hF, 1, 4'h0, 8'h00, 1, 1));
    vecs.push_back(mk(1, 4'h0, 1, 8'h24, 4'hF, 0, 4'h2, 8'h23, 1, 0));
    vecs.push_back(mk(1, 4'h0, 1, 8'h24, 4'hF, 0, 4'h0, 8'h00, 1, 0));
    vecs.push_back(mk(1, 4'h0, 1, 8'h24, 4'hF, 0, 4'h0, 8'h00, 1, 0));
    vecs.push_back(mk(1, 4'h4, 1, 8'h30, 4'hF, 0, 4'h0, 8'h00, 1, 0));
    vecs.push_back(mk(1, 4'h4, 1, 8'h31, 4'h0, 1, 4'h0, 8'h00, 2, 0));
    vecs.push_back(mk(1, 4'h4, 0, 8'h00, 4'h0, 0, 4'h4, 8'h31, 2, 0));
    vecs.push_back(mk(0, 4'h4, 0, 8'h00, 4'h0, 0, 4'h4, 8'h31, 2, 0));
    vecs.push_back(mk(1, 4'h4, 0, 8'h00, 4'hF, 0, 4'h0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 4'h4, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 2, 0));

    rst_n = 1'b0; en = 4'hF; i_valid = 1'b1; i_data = 8'h99; y_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i], i);

    // Fully masked: the block must idle with i_ready low and the select frozen.
    en = 4'h0; i_valid = 1'b1; i_data = 8'h77;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_i_ready", 1000 + c, 32'(i_ready), 32'd0);
      chk("idle_s", 1000 + c, 32'(s), 32'd2);
      chk("idle_y_valid", 1000 + c, 32'(y_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    en = 4'hF;
    @(negedge clk);
    chk("wake_i_ready", 2000, 32'(i_ready), 32'd1);
    chk("wake_s", 2000, 32'(s), 32'd2);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("wake_y_valid", 2001, 32'(y_valid), 32'h4);
    chk("wake_y_data", 2001, 32'(y_data), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
